pipe_issue_ctrl: RTL and testbench

Issue controller and arbiter in front of the 4-stage regbank/ALU/writeback/store pipeline. Two requesters offer packed instructions over valid/ready. The block picks one eligible instruction per cycle (round-robin) and blocks RAW hazards against in-flight destination registers with a shift-register scoreboard. Accepted instructions are driven as registered rs1/rs2/rd/func/addr fields into pipeline stage 1.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_issue_ctrl_if.sv | 13 +
 rtl/pipe_scoreboard.sv | 55 +++++
 rtl/pipe_issue_ctrl.sv | 99 +++++++++
 tb/tb_pipe_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared instruction layout, func opcodes and operand-usage decode for the
// issue controller and its scoreboard.
package pipe_pkg;

    localparam int INSTR_W  = 24;
    localparam int FUNC_LSB = 20;
    localparam int RD_LSB   = 16;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_LSB = 0;

    typedef logic [3:0] reg_idx_t;

    typedef enum logic [3:0] {
        FUNC_ADD = 4'd0,
        FUNC_SUB = 4'd1,
        FUNC_AND = 4'd2,
        FUNC_NOT = 4'd3,
        FUNC_MOV = 4'd4,
        FUNC_OR  = 4'd5,
        FUNC_XOR = 4'd6,
        FUNC_CMP = 4'd7,
        FUNC_LD  = 4'd8,
        FUNC_ST  = 4'd9,
        FUNC_SHR = 4'd10,
        FUNC_SHL = 4'd11
    } func_e;

    typedef struct packed {
        logic [3:0] func;
        reg_idx_t   rd;
        reg_idx_t   rs1;
        reg_idx_t   rs2;
        logic [7:0] addr;
    } instr_t;

    function automatic logic is_legal(input logic [3:0] func);
        return func <= 4'd11;
    endfunction

    function automatic logic uses_rs1(input logic [3:0] func);
        case (func)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [3:0] func);
        case (func)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Requester-side valid/ready bundle: two instruction sources, one-hot accept.
interface pipe_issue_ctrl_if;
    import pipe_pkg::*;

    logic [1:0]         req_valid;
    logic [INSTR_W-1:0] req_instr0;
    logic [INSTR_W-1:0] req_instr1;
    logic [1:0]         req_ready;

    modport master (output req_valid, req_instr0, req_instr1, input req_ready);
    modport slave  (input req_valid, req_instr0, req_instr1, output req_ready);

endinterface

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with a
// combinational RAW lookup for both requester heads.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       push_valid,
    input  reg_idx_t   push_rd,
    input  logic [3:0] func0,
    input  reg_idx_t   rs1_0,
    input  reg_idx_t   rs2_0,
    input  logic [3:0] func1,
    input  reg_idx_t   rs1_1,
    input  reg_idx_t   rs2_1,
    output logic       hazard0,
    output logic       hazard1,
    output logic       busy
);

    logic [SB_DEPTH-1:0] sb_valid;
    reg_idx_t            sb_rd [SB_DEPTH];

    // Shifts every cycle, hold included, so entries age out during a freeze.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sb_valid <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= '0;
        end else begin
            sb_valid <= {sb_valid[SB_DEPTH-2:0], push_valid};
            sb_rd[0] <= push_rd;
            for (int i = 1; i < SB_DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
        end
    end

    always_comb begin
        hazard0 = 1'b0;
        hazard1 = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i]) begin
                if ((uses_rs1(func0) && rs1_0 == sb_rd[i]) ||
                    (uses_rs2(func0) && rs2_0 == sb_rd[i]))
                    hazard0 = 1'b1;
                if ((uses_rs1(func1) && rs1_1 == sb_rd[i]) ||
                    (uses_rs2(func1) && rs2_1 == sb_rd[i]))
                    hazard1 = 1'b1;
            end
        end
    end

    assign busy = |sb_valid;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Round-robin issue arbiter with RAW blocking in front of the 4-stage
// regbank/ALU/writeback/store pipeline.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk1,
    input  logic                 rst,
    pipe_issue_ctrl_if.slave     req,
    input  logic                 hold,
    output logic                 iss_valid,
    output reg_idx_t             iss_rs1,
    output reg_idx_t             iss_rs2,
    output reg_idx_t             iss_rd,
    output logic [3:0]           iss_func,
    output logic [7:0]           iss_addr,
    output logic                 iss_src,
    output logic                 illegal,
    output logic                 busy,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int SB_DEPTH = WB_LAT + 1;

    instr_t     instr0, instr1, sel_instr;
    logic       hazard0, hazard1;
    logic [1:0] elig;
    logic       gnt_any, gnt_idx, sel_legal, push_valid, stall_ev;
    logic       rr_ptr;

    assign instr0 = instr_t'(req.req_instr0);
    assign instr1 = instr_t'(req.req_instr1);

    pipe_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk1       (clk1),
        .rst        (rst),
        .push_valid (push_valid),
        .push_rd    (sel_instr.rd),
        .func0      (instr0.func),
        .rs1_0      (instr0.rs1),
        .rs2_0      (instr0.rs2),
        .func1      (instr1.func),
        .rs1_1      (instr1.rs1),
        .rs2_1      (instr1.rs2),
        .hazard0    (hazard0),
        .hazard1    (hazard1),
        .busy       (busy)
    );

    assign elig[0] = req.req_valid[0] & ~hazard0 & ~hold;
    assign elig[1] = req.req_valid[1] & ~hazard1 & ~hold;

    always_comb begin
        gnt_any = |elig;
        gnt_idx = (elig == 2'b11) ? rr_ptr : elig[1];
        req.req_ready = 2'b00;
        if (gnt_any) req.req_ready = gnt_idx ? 2'b10 : 2'b01;
    end

    assign sel_instr  = gnt_idx ? instr1 : instr0;
    assign sel_legal  = is_legal(sel_instr.func);
    // Illegal funcs are consumed but never occupy a scoreboard slot.
    assign push_valid = gnt_any & sel_legal;
    assign stall_ev   = ~hold & (|req.req_valid) & ~gnt_any;

    always_ff @(posedge clk1) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_func  <= '0;
            iss_addr  <= '0;
            iss_src   <= 1'b0;
            illegal   <= 1'b0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_any) rr_ptr <= ~gnt_idx;
            iss_valid <= push_valid;
            illegal   <= gnt_any & ~sel_legal;
            if (push_valid) begin
                iss_rs1  <= sel_instr.rs1;
                iss_rs2  <= sel_instr.rs2;
                iss_rd   <= sel_instr.rd;
                iss_func <= sel_instr.func;
                iss_addr <= sel_instr.addr;
                iss_src  <= gnt_idx;
                if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
            end
            if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: streaming, RAW stalls, round-robin,
// illegal funcs, hold and mid-run reset.
module tb_pipe_issue_ctrl;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        hold;
    logic        iss_valid, iss_src, illegal, busy;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]  iss_addr;
    logic [15:0] issue_cnt, stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_issue = 0;
    int exp_stall = 0;

    pipe_issue_ctrl_if rif ();

    pipe_issue_ctrl #(.WB_LAT(2), .CNT_W(16)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .req       (rif),
        .hold      (hold),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_func  (iss_func),
        .iss_addr  (iss_addr),
        .iss_src   (iss_src),
        .illegal   (illegal),
        .busy      (busy),
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    function automatic logic [23:0] mk(input int f, input int rd, input int rs1,
                                       input int rs2, input int addr);
        return {f[3:0], rd[3:0], rs1[3:0], rs2[3:0], addr[7:0]};
    endfunction

    task automatic drain();
        rif.req_valid = 2'b00;
        repeat (3) tick();
        chk("drain_busy", busy, 0);
    endtask

    // Producer ADD rd=5, then a dependent instruction expected to wait nstall cycles.
    task automatic raw_case(input int f_dep, input int rs1, input int rs2, input int nstall);
        rif.req_valid  = 2'b01;
        rif.req_instr0 = mk(0, 5, 1, 2, 0);
        #1 chk("raw_prod_ready", rif.req_ready, 2'b01);
        tick();
        exp_issue++;
        rif.req_instr0 = mk(f_dep, 6, rs1, rs2, 8'h40);
        for (int c = 0; c < nstall; c++) begin
            #1 chk("raw_stall_ready", rif.req_ready, 2'b00);
            tick();
            exp_stall++;
        end
        #1 chk("raw_dep_ready", rif.req_ready, 2'b01);
        tick();
        exp_issue++;
        chk("raw_iss_valid", iss_valid, 1);
        chk("raw_iss_func", iss_func, f_dep);
        chk("raw_issue_cnt", issue_cnt, exp_issue);
        chk("raw_stall_cnt", stall_cnt, exp_stall);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        rif.req_valid  = 2'b00;
        rif.req_instr0 = '0;
        rif.req_instr1 = '0;
        repeat (2) tick();
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_iss_rd", iss_rd, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_iss_valid", iss_valid, 0);

        // independent back-to-back stream from requester 0
        for (int k = 1; k <= 5; k++) begin
            rif.req_valid  = 2'b01;
            rif.req_instr0 = mk(0, k, 8, 9, k);
            #1 chk("stream_ready", rif.req_ready, 2'b01);
            tick();
            exp_issue++;
            chk("stream_iss_valid", iss_valid, 1);
            chk("stream_iss_rd", iss_rd, k);
            chk("stream_iss_addr", iss_addr, k);
            chk("stream_iss_src", iss_src, 0);
        end
        rif.req_valid = 2'b00;
        tick();
        chk("stream_idle_valid", iss_valid, 0);
        chk("stream_issue_cnt", issue_cnt, 5);
        chk("stream_stall_cnt", stall_cnt, 0);
        chk("stream_busy", busy, 1);
        repeat (2) tick();
        chk("stream_busy_drop", busy, 0);

        raw_case(1, 5, 3, 3);
        raw_case(4, 3, 5, 3);
        raw_case(8, 3, 5, 0);
        raw_case(4, 5, 3, 0);

        // round-robin; every earlier grant went to req0, so req1 leads
        rif.req_valid  = 2'b11;
        rif.req_instr0 = mk(0, 10, 1, 2, 0);
        rif.req_instr1 = mk(0, 11, 3, 4, 0);
        for (int c = 0; c < 4; c++) begin
            #1 chk("rr_ready", rif.req_ready, (c % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            exp_issue++;
            chk("rr_iss_src", iss_src, (c % 2 == 0) ? 1 : 0);
            chk("rr_iss_rd", iss_rd, (c % 2 == 0) ? 11 : 10);
        end
        drain();

        // req1 head hazarded on r7: req0 wins every cycle until it clears
        rif.req_valid  = 2'b01;
        rif.req_instr0 = mk(0, 7, 1, 2, 0);
        #1 chk("rrhz_prod_ready", rif.req_ready, 2'b01);
        tick();
        exp_issue++;
        rif.req_valid  = 2'b11;
        rif.req_instr0 = mk(0, 13, 1, 2, 0);
        rif.req_instr1 = mk(0, 12, 7, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("rrhz_ready", rif.req_ready, 2'b01);
            tick();
            exp_issue++;
        end
        #1 chk("rrhz_clear_ready", rif.req_ready, 2'b10);
        tick();
        exp_issue++;
        chk("rrhz_iss_src", iss_src, 1);
        chk("rrhz_iss_rd", iss_rd, 12);
        chk("rrhz_stall_cnt", stall_cnt, exp_stall);
        drain();

        // illegal func from req1
        rif.req_valid  = 2'b10;
        rif.req_instr1 = mk(13, 3, 3, 3, 0);
        #1 chk("ill_ready", rif.req_ready, 2'b10);
        tick();
        rif.req_valid = 2'b00;
        chk("ill_pulse", illegal, 1);
        chk("ill_iss_valid", iss_valid, 0);
        chk("ill_busy", busy, 0);
        chk("ill_issue_cnt", issue_cnt, exp_issue);
        chk("ill_iss_rd_held", iss_rd, 12);
        tick();
        chk("ill_pulse_end", illegal, 0);

        // hold with pending requests; scoreboard keeps ageing
        rif.req_valid  = 2'b01;
        rif.req_instr0 = mk(0, 4, 1, 2, 0);
        #1 chk("hold_prod_ready", rif.req_ready, 2'b01);
        tick();
        exp_issue++;
        hold = 1'b1;
        rif.req_valid  = 2'b11;
        rif.req_instr0 = mk(0, 14, 1, 2, 0);
        rif.req_instr1 = mk(0, 15, 1, 2, 0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("hold_ready", rif.req_ready, 2'b00);
            tick();
            if (c == 0) chk("hold_busy", busy, 1);
        end
        chk("hold_busy_drop", busy, 0);
        chk("hold_stall_cnt", stall_cnt, exp_stall);
        chk("hold_iss_valid", iss_valid, 0);
        hold = 1'b0;
        #1 chk("unhold_ready", rif.req_ready, 2'b10);
        tick();
        exp_issue++;
        chk("unhold_iss_src", iss_src, 1);
        chk("unhold_issue_cnt", issue_cnt, exp_issue);

        // reset mid-operation with an entry in flight
        rif.req_valid  = 2'b01;
        rif.req_instr0 = mk(0, 5, 1, 2, 0);
        #1 chk("mrst_prod_ready", rif.req_ready, 2'b01);
        tick();
        chk("mrst_busy_pre", busy, 1);
        rst = 1'b1;
        rif.req_valid = 2'b00;
        tick();
        rst = 1'b0;
        exp_issue = 0;
        exp_stall = 0;
        chk("mrst_busy", busy, 0);
        chk("mrst_iss_valid", iss_valid, 0);
        chk("mrst_issue_cnt", issue_cnt, 0);
        chk("mrst_stall_cnt", stall_cnt, 0);
        rif.req_valid  = 2'b01;
        rif.req_instr0 = mk(1, 6, 5, 5, 0);
        #1 chk("mrst_dep_ready", rif.req_ready, 2'b01);
        tick();
        exp_issue++;
        rif.req_valid = 2'b00;
        chk("mrst_dep_iss_valid", iss_valid, 1);
        chk("mrst_dep_issue_cnt", issue_cnt, exp_issue);
        chk("mrst_dep_stall_cnt", stall_cnt, exp_stall);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
